// File: rtl/mem_responder.sv
// Memory-side responder: word RAM with post-reset clear sweep, LED register and synchronized switches.
// Optional sticky unmapped-access trap enabled by defining MEM_RESPONDER_TRAP_EN.
module mem_responder #(
    parameter int                  ADDR_W         = 9,
    parameter int                  DATA_W         = 16,
    parameter int                  RAM_WORDS      = 256,
    parameter logic [ADDR_W-1:0]   LED_ADDR       = 9'h100,
    parameter logic [ADDR_W-1:0]   SW_ADDR        = 9'h140,
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              mem_ready,
    input  logic [7:0]        switches,
    output logic [7:0]        leds
`ifdef MEM_RESPONDER_TRAP_EN
    ,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
`endif
);

    localparam int                PTR_W    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RAM_WORDS - 1);
    localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(RAM_WORDS);
    localparam logic [1:0]        CMD_RD   = 2'b01;
    localparam logic [1:0]        CMD_WR   = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t              state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [DATA_W-1:0]   read_data_r;
    logic                rd_valid_r;
    logic                mem_ready_r;
    logic [7:0]          leds_r;
    logic [7:0]          sw_meta_r;
    logic [7:0]          sw_sync_r;
    logic [DATA_W-1:0]   ram_r [RAM_WORDS];

    logic                is_ram_s;
    logic                is_led_s;
    logic                is_sw_s;
    logic                accept_s;
    logic                rd_s;
    logic                wr_s;
    logic [DATA_W-1:0]   rd_mux_s;
    logic                ram_we_s;
    logic [PTR_W-1:0]    ram_waddr_s;
    logic [DATA_W-1:0]   ram_wdata_s;

    // Address decode and command qualification; nothing is accepted while reset is asserted.
    always_comb begin
        is_ram_s = (mem_addr < RAM_TOP);
        is_led_s = (mem_addr == LED_ADDR);
        is_sw_s  = (mem_addr == SW_ADDR);
        accept_s = reset && (state_r == ST_SERVE) && mem_ready_r;
        rd_s     = accept_s && (mem_cmd == CMD_RD);
        wr_s     = accept_s && (mem_cmd == CMD_WR);
    end

    // Read data selection across RAM, LED register and synchronized switches.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        if (is_ram_s) begin
            rd_mux_s = ram_r[mem_addr[PTR_W-1:0]];
        end else if (is_led_s) begin
            rd_mux_s = {{(DATA_W-8){1'b0}}, leds_r};
        end else if (is_sw_s) begin
            rd_mux_s = {{(DATA_W-8){1'b0}}, sw_sync_r};
        end else begin
            rd_mux_s = {DATA_W{1'b0}};
        end
    end

    // Single RAM write port shared by the clear sweep and CPU writes.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ptr_r;
        ram_wdata_s = {DATA_W{1'b0}};
        if (reset && (state_r == ST_CLEAR)) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = ptr_r;
            ram_wdata_s = {DATA_W{1'b0}};
        end else if (wr_s && is_ram_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = mem_addr[PTR_W-1:0];
            ram_wdata_s = write_data;
        end else begin
            ram_we_s    = 1'b0;
        end
    end

    // RAM storage; contents are initialised by the clear sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Control FSM, read response, LED register and switch synchronizer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            ptr_r       <= {PTR_W{1'b0}};
            read_data_r <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            leds_r      <= 8'h00;
            sw_meta_r   <= 8'h00;
            sw_sync_r   <= 8'h00;
        end else begin
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    mem_ready_r <= 1'b0;
                    if (ptr_r == PTR_LAST) begin
                        state_r     <= ST_SERVE;
                        ptr_r       <= {PTR_W{1'b0}};
                        mem_ready_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + PTR_W'(1);
                    end
                end
                ST_SERVE: begin
                    mem_ready_r <= 1'b1;
                    if (rd_s) begin
                        read_data_r <= rd_mux_s;
                        rd_valid_r  <= 1'b1;
                    end
                    if (wr_s && is_led_s) begin
                        leds_r <= write_data[7:0];
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    ptr_r       <= {PTR_W{1'b0}};
                    mem_ready_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_RESPONDER_TRAP_EN
    logic              err_r;
    logic [ADDR_W-1:0] err_addr_r;

    // Sticky capture of the first accepted access to an unmapped address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_r      <= 1'b0;
            err_addr_r <= {ADDR_W{1'b0}};
        end else if ((rd_s || wr_s) && !(is_ram_s || is_led_s || is_sw_s) && !err_r) begin
            err_r      <= 1'b1;
            err_addr_r <= mem_addr;
        end
    end

    assign err      = err_r;
    assign err_addr = err_addr_r;
`endif

    assign read_data = read_data_r;
    assign rd_valid  = rd_valid_r;
    assign mem_ready = mem_ready_r;
    assign leds      = leds_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a behavioural model is checked every cycle, plus literal spot checks.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;
    logic        mem_ready;
    logic [7:0]  switches;
    logic [7:0]  leds;
`ifdef MEM_RESPONDER_TRAP_EN
    logic        err;
    logic [8:0]  err_addr;
`endif

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .mem_ready  (mem_ready),
        .switches   (switches),
        .leds       (leds)
`ifdef MEM_RESPONDER_TRAP_EN
        ,
        .err        (err),
        .err_addr   (err_addr)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [1:0] NONE = 2'b00, RD = 2'b01, WR = 2'b10, RSV = 2'b11;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] sw_drv = 8'h00;

    // Behavioural model state
    logic [15:0] m_ram [256];
    logic [7:0]  m_leds, m_sw1, m_sw2;
    logic        m_ready, m_rv, m_err;
    logic [15:0] m_rdata;
    logic [8:0]  m_err_addr;
    int          m_clear_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                              input logic [15:0] wd, input logic [7:0] sw);
        logic mapped;
        if (!rst) begin
            for (int i = 0; i < 256; i++) m_ram[i] = 16'h0000;
            m_leds = 8'h00; m_sw1 = 8'h00; m_sw2 = 8'h00;
            m_ready = 1'b0; m_rv = 1'b0; m_rdata = 16'h0000;
            m_clear_left = 256; m_err = 1'b0; m_err_addr = 9'h000;
            return;
        end
        m_rv = 1'b0;
        if (m_clear_left > 0) begin
            m_clear_left--;
            m_ready = (m_clear_left == 0);
        end else begin
            m_ready = 1'b1;
            mapped = (addr < 9'h100) || (addr == 9'h100) || (addr == 9'h140);
            if (cmd == RD) begin
                m_rv = 1'b1;
                if (addr < 9'h100)       m_rdata = m_ram[addr[7:0]];
                else if (addr == 9'h100) m_rdata = {8'h00, m_leds};
                else if (addr == 9'h140) m_rdata = {8'h00, m_sw2};
                else                     m_rdata = 16'h0000;
            end else if (cmd == WR) begin
                if (addr < 9'h100)       m_ram[addr[7:0]] = wd;
                else if (addr == 9'h100) m_leds = wd[7:0];
            end
            if ((cmd == RD || cmd == WR) && !mapped && !m_err) begin
                m_err = 1'b1;
                m_err_addr = addr;
            end
        end
        m_sw2 = m_sw1;
        m_sw1 = sw;
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic tick(input logic rst, input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
        reset = rst; mem_cmd = cmd; mem_addr = addr; write_data = wd; switches = sw_drv;
        @(posedge clk);
        model_edge(rst, cmd, addr, wd, sw_drv);
        @(negedge clk);
        chk("mem_ready", mem_ready, m_ready);
        chk("rd_valid", rd_valid, m_rv);
        chk("read_data", read_data, m_rdata);
        chk("leds", leds, m_leds);
`ifdef MEM_RESPONDER_TRAP_EN
        chk("err", err, m_err);
        chk("err_addr", err_addr, m_err_addr);
`endif
    endtask

    task automatic count_clear(input string name, input logic [8:0] addr, input logic [15:0] wd);
        int cnt = 1;
        int guard = 0;
        while (1) begin
            tick(1'b1, (guard % 2 == 0) ? WR : RD, addr, wd);
            guard++;
            if (mem_ready === 1'b1) break;
            cnt++;
            if (guard > 400) break;
        end
        chk(name, cnt, 256);
    endtask

    initial begin
        reset = 1'b0; mem_cmd = NONE; mem_addr = 9'h000; write_data = 16'h0000; switches = 8'h00;

        tick(1'b0, NONE, 9'h000, 16'h0000);
        chk("lit_reset_ready", mem_ready, 1'b0);
        chk("lit_reset_rdata", read_data, 16'h0000);
        chk("lit_reset_leds", leds, 8'h00);
        count_clear("lit_clear_len", 9'h005, 16'hFFFF);

        tick(1'b1, RD, 9'h005, 16'h0000);
        chk("lit_rd005_valid", rd_valid, 1'b1);
        chk("lit_rd005_data", read_data, 16'h0000);
        tick(1'b1, NONE, 9'h000, 16'h0000);
        chk("lit_rv_pulse", rd_valid, 1'b0);

        tick(1'b1, WR, 9'h010, 16'hBEEF);
        tick(1'b1, RD, 9'h010, 16'h0000);
        chk("lit_raw_beef", read_data, 16'hBEEF);

        sw_drv = 8'hA5;
        for (int i = 0; i < 3; i++) tick(1'b1, NONE, 9'h000, 16'h0000);
        tick(1'b1, RD, 9'h140, 16'h0000);
        chk("lit_sw_a5", read_data, 16'h00A5);

        tick(1'b1, WR, 9'h100, 16'h1234);
        chk("lit_leds_34", leds, 8'h34);
        tick(1'b1, RD, 9'h100, 16'h0000);
        chk("lit_rd_led", read_data, 16'h0034);
        tick(1'b1, WR, 9'h0C0, 16'h7777);
        chk("lit_leds_hold", leds, 8'h34);
        tick(1'b1, RD, 9'h0C0, 16'h0000);
        chk("lit_rd_0c0", read_data, 16'h7777);
        tick(1'b1, RSV, 9'h0C0, 16'h0000);
        chk("lit_rsv_novalid", rd_valid, 1'b0);

        tick(1'b1, WR, 9'h0FF, 16'hABCD);
        tick(1'b1, RD, 9'h0FF, 16'h0000);
        chk("lit_top_word", read_data, 16'hABCD);
        tick(1'b1, RD, 9'h1FF, 16'h0000);
        chk("lit_unmapped_rd", read_data, 16'h0000);
        tick(1'b1, WR, 9'h150, 16'h9999);
        tick(1'b1, WR, 9'h140, 16'h00FF);
        tick(1'b1, RD, 9'h101, 16'h0000);
        chk("lit_rd_101", read_data, 16'h0000);
        tick(1'b1, RD, 9'h000, 16'h0000);
        chk("lit_no_wrap", read_data, 16'h0000);
`ifdef MEM_RESPONDER_TRAP_EN
        chk("lit_err", err, 1'b1);
        chk("lit_err_addr", err_addr, 9'h1FF);
`endif

        tick(1'b1, WR, 9'h020, 16'h1111);
        tick(1'b1, RD, 9'h020, 16'h0000);
        chk("lit_pre_020", read_data, 16'h1111);

        tick(1'b0, NONE, 9'h000, 16'h0000);
`ifdef MEM_RESPONDER_TRAP_EN
        chk("lit_err_cleared", err, 1'b0);
`endif
        for (int i = 0; i < 100; i++) tick(1'b1, WR, 9'h020, 16'h5555);
        tick(1'b0, NONE, 9'h000, 16'h0000);
        count_clear("lit_restart_len", 9'h020, 16'h5555);
        tick(1'b1, RD, 9'h020, 16'h0000);
        chk("lit_020_cleared", read_data, 16'h0000);
        tick(1'b1, NONE, 9'h000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
